// File: rtl/clk_select_seq.sv
// Select sequencer for a two-input clock mux: gates the muxed clock off, pulses
// the mux select-enable inside the gated window, then re-opens the gate.
module clk_select_seq #(
  parameter int QUIESCE_CYCLES = 4,
  parameter int SETTLE_CYCLES  = 4,
  parameter int CNT_WIDTH      = 8
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic REQ,
  input  logic REQ_SEL,
  output logic REQ_RDY,
  output logic ACK,
  output logic CUR_SEL,
  output logic SELECT,
  output logic SELECT_ENABLE,
  output logic GATE_OUT
);

  typedef enum logic [2:0] {
    S_INIT, S_IDLE, S_QUIESCE, S_SWITCH, S_SETTLE, S_DONE
  } state_e;

  localparam logic [CNT_WIDTH-1:0] QLOAD = CNT_WIDTH'(QUIESCE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] SLOAD = CNT_WIDTH'(SETTLE_CYCLES - 1);

  state_e               state_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic                 tgt_q;
  logic                 rdy_q, ack_q, cur_q, sel_q, sel_en_q, gate_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= S_INIT;
      cnt_q    <= '0;
      tgt_q    <= 1'b0;
      rdy_q    <= 1'b0;
      ack_q    <= 1'b0;
      cur_q    <= 1'b0;
      sel_q    <= 1'b0;
      sel_en_q <= 1'b0;
      gate_q   <= 1'b0;
    end else begin
      case (state_q)
        // Force the mux register to B so CUR_SEL=0 is true from the start.
        S_INIT: begin
          sel_en_q <= 1'b1;
          sel_q    <= 1'b0;
          state_q  <= S_IDLE;
        end
        S_IDLE: begin
          sel_en_q <= 1'b0;
          ack_q    <= 1'b0;
          gate_q   <= 1'b1;
          rdy_q    <= 1'b1;
          if (REQ && rdy_q) begin
            tgt_q <= REQ_SEL;
            rdy_q <= 1'b0;
            if (REQ_SEL == cur_q) begin
              ack_q   <= 1'b1;
              state_q <= S_DONE;
            end else begin
              gate_q  <= 1'b0;
              cnt_q   <= QLOAD;
              state_q <= S_QUIESCE;
            end
          end
        end
        S_QUIESCE: begin
          if (cnt_q == '0) begin
            sel_q    <= tgt_q;
            sel_en_q <= 1'b1;
            state_q  <= S_SWITCH;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_SWITCH: begin
          sel_en_q <= 1'b0;
          cnt_q    <= SLOAD;
          state_q  <= S_SETTLE;
        end
        S_SETTLE: begin
          if (cnt_q == '0) begin
            ack_q   <= 1'b1;
            cur_q   <= tgt_q;
            gate_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_DONE: begin
          ack_q   <= 1'b0;
          rdy_q   <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_INIT;
      endcase
    end
  end

  assign REQ_RDY       = rdy_q;
  assign ACK           = ack_q;
  assign CUR_SEL       = cur_q;
  assign SELECT        = sel_q;
  assign SELECT_ENABLE = sel_en_q;
  assign GATE_OUT      = gate_q;

endmodule
